// File: rtl/tdm_mac_filt.sv
`default_nettype none
// ============================================================================
// Module   : tdm_mac_filt
// Brief    : Time-shared single-MAC FIR pulse-shaping filter with run-time
//            loadable coefficients and an optional linear-phase fold.
// Revision : 1.0 - initial release
// ============================================================================
module tdm_mac_filt #(
    parameter int WIDTH     = 18,
    parameter int LENGTH    = 93,
    parameter int SYMMETRIC = 1,
    parameter int ACCW      = 2*WIDTH+7,
    parameter int ADDRW     = 7
) (
    input  logic                    sys_clk,
    input  logic                    reset,
    input  logic                    sam_clk_en,
    input  logic signed [WIDTH-1:0] x_in,
    input  logic                    coef_wr,
    input  logic [ADDRW-1:0]        coef_addr,
    input  logic signed [WIDTH-1:0] coef_data,
    output logic                    coef_ready,
    output logic signed [WIDTH-1:0] y,
    output logic                    y_valid,
    output logic                    overrun
);

    localparam int c_N  = (SYMMETRIC != 0) ? (LENGTH + 1) / 2 : LENGTH;
    localparam int c_PW = 2*WIDTH + 1;
    localparam logic [ADDRW-1:0] c_LAST = ADDRW'(c_N - 1);
    localparam logic signed [ACCW-1:0] c_YMAX = {{(ACCW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [ACCW-1:0] c_YMIN = {{(ACCW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MAC  = 2'd1,
        ST_OUT  = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic signed [WIDTH-1:0] r_x    [0:LENGTH-1];
    logic signed [WIDTH-1:0] r_coef [0:c_N-1];
    logic [ADDRW-1:0]        r_k;
    logic signed [ACCW-1:0]  r_acc;
    logic signed [WIDTH-1:0] r_y;
    logic                    r_y_valid;
    logic                    r_overrun;

    logic signed [WIDTH-1:0] w_xa;
    logic signed [WIDTH-1:0] w_coef;
    logic signed [WIDTH:0]   w_term;
    logic signed [c_PW-1:0]  w_coef_x;
    logic signed [c_PW-1:0]  w_term_x;
    logic signed [c_PW-1:0]  w_prod;
    logic signed [ACCW-1:0]  w_prod_ext;
    logic signed [ACCW-1:0]  w_shift;
    logic signed [WIDTH-1:0] w_y_sat;

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (sam_clk_en) w_state_nxt = ST_MAC;
            ST_MAC:  if (r_k == c_LAST) w_state_nxt = ST_OUT;
            ST_OUT:  w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Tap k selects the newest-side sample and its coefficient.
    always_comb begin
        w_xa   = '0;
        w_coef = '0;
        for (int i = 0; i < c_N; i++) begin
            if (r_k == ADDRW'(i)) begin
                w_xa   = r_x[i];
                w_coef = r_coef[i];
            end
        end
    end

    generate
        if (SYMMETRIC != 0) begin : g_sym
            logic signed [WIDTH-1:0] w_xb;
            logic                    w_centre;
            always_comb begin
                w_xb = '0;
                for (int i = 0; i < c_N; i++) begin
                    if (r_k == ADDRW'(i)) w_xb = r_x[LENGTH-1-i];
                end
            end
            // Odd-length centre tap has no mirror partner and must not be doubled.
            assign w_centre = (LENGTH % 2 == 1) && (r_k == c_LAST);
            assign w_term   = w_centre ? {w_xa[WIDTH-1], w_xa}
                                       : ({w_xa[WIDTH-1], w_xa} + {w_xb[WIDTH-1], w_xb});
        end else begin : g_direct
            assign w_term = {w_xa[WIDTH-1], w_xa};
        end
    endgenerate

    assign w_coef_x   = {{(WIDTH+1){w_coef[WIDTH-1]}}, w_coef};
    assign w_term_x   = {{WIDTH{w_term[WIDTH]}}, w_term};
    assign w_prod     = w_coef_x * w_term_x;
    assign w_prod_ext = {{(ACCW-c_PW){w_prod[c_PW-1]}}, w_prod};
    assign w_shift    = r_acc >>> (WIDTH-1);

    always_comb begin
        if (w_shift > c_YMAX) begin
            w_y_sat = c_YMAX[WIDTH-1:0];
        end else if (w_shift < c_YMIN) begin
            w_y_sat = c_YMIN[WIDTH-1:0];
        end else begin
            w_y_sat = w_shift[WIDTH-1:0];
        end
    end

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            for (int i = 0; i < LENGTH; i++) r_x[i] <= '0;
            r_acc     <= '0;
            r_k       <= '0;
            r_y       <= '0;
            r_y_valid <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_y_valid <= 1'b0;
            if (sam_clk_en && (r_state != ST_IDLE)) r_overrun <= 1'b1;
            case (r_state)
                ST_IDLE: begin
                    if (sam_clk_en) begin
                        for (int i = LENGTH-1; i > 0; i--) r_x[i] <= r_x[i-1];
                        r_x[0] <= x_in;
                        r_acc  <= '0;
                        r_k    <= '0;
                    end
                end
                ST_MAC: begin
                    r_acc <= r_acc + w_prod_ext;
                    r_k   <= r_k + ADDRW'(1);
                end
                ST_OUT: begin
                    r_y       <= w_y_sat;
                    r_y_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Coefficient port is only open while idle so a MAC pass sees a stable set.
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            for (int i = 0; i < c_N; i++) r_coef[i] <= '0;
        end else if (coef_wr && (r_state == ST_IDLE)) begin
            for (int i = 0; i < c_N; i++) begin
                if (coef_addr == ADDRW'(i)) r_coef[i] <= coef_data;
            end
        end
    end

    assign coef_ready = (r_state == ST_IDLE);
    assign y          = r_y;
    assign y_valid    = r_y_valid;
    assign overrun    = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_tdm_mac_filt.sv
`default_nettype none
// ============================================================================
// Module   : tb_tdm_mac_filt
// Brief    : Self-checking bench driving a direct and a folded LENGTH=5 filter
//            from one stimulus bus against a full-response reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tdm_mac_filt;

    localparam int W  = 18;
    localparam int L  = 5;
    localparam int AW = 7;

    logic                sys_clk = 1'b0;
    logic                reset;
    logic                sam_clk_en;
    logic signed [W-1:0] x_in;
    logic                coef_wr;
    logic [AW-1:0]       coef_addr;
    logic signed [W-1:0] coef_data;
    logic                cr_d, cr_s, yv_d, yv_s, ov_d, ov_s;
    logic signed [W-1:0] y_d, y_s;

    int checks   = 0;
    int failures = 0;

    // Reference model: accepted samples (newest first) and the full impulse response.
    longint hist[$];
    longint cd[L];
    longint cs[3];

    always #5 sys_clk = ~sys_clk;

    tdm_mac_filt #(.WIDTH(W), .LENGTH(L), .SYMMETRIC(0), .ACCW(2*W+7), .ADDRW(AW)) u_dir (
        .sys_clk(sys_clk), .reset(reset), .sam_clk_en(sam_clk_en), .x_in(x_in),
        .coef_wr(coef_wr), .coef_addr(coef_addr), .coef_data(coef_data),
        .coef_ready(cr_d), .y(y_d), .y_valid(yv_d), .overrun(ov_d)
    );

    tdm_mac_filt #(.WIDTH(W), .LENGTH(L), .SYMMETRIC(1), .ACCW(2*W+7), .ADDRW(AW)) u_sym (
        .sys_clk(sys_clk), .reset(reset), .sam_clk_en(sam_clk_en), .x_in(x_in),
        .coef_wr(coef_wr), .coef_addr(coef_addr), .coef_data(coef_data),
        .coef_ready(cr_s), .y(y_s), .y_valid(yv_s), .overrun(ov_s)
    );

    function automatic longint hx(int j);
        return (j < hist.size()) ? hist[j] : 64'sd0;
    endfunction

    function automatic longint scale(longint acc);
        longint s;
        s = acc >>> 17;
        if (s > 131071) s = 131071;
        else if (s < -131072) s = -131072;
        return s;
    endfunction

    function automatic longint exp_dir();
        longint acc = 0;
        for (int j = 0; j < L; j++) acc += cd[j] * hx(j);
        return scale(acc);
    endfunction

    // The folded filter is equivalent to a direct one with a mirrored response.
    function automatic longint exp_sym();
        longint acc = 0;
        for (int j = 0; j < L; j++) acc += cs[(j <= L-1-j) ? j : L-1-j] * hx(j);
        return scale(acc);
    endfunction

    task automatic model_push(input longint v);
        hist.push_front(v);
        if (hist.size() > L) hist.delete(hist.size()-1);
    endtask

    task automatic do_reset();
        @(negedge sys_clk);
        reset = 1'b1; sam_clk_en = 1'b0; coef_wr = 1'b0;
        repeat (2) @(negedge sys_clk);
        reset = 1'b0;
        hist.delete();
        for (int j = 0; j < L; j++) cd[j] = 0;
        for (int j = 0; j < 3; j++) cs[j] = 0;
    endtask

    task automatic load_coef(input logic [AW-1:0] a, input logic signed [W-1:0] d);
        @(negedge sys_clk);
        coef_wr = 1'b1; coef_addr = a; coef_data = d;
        @(negedge sys_clk);
        coef_wr = 1'b0;
        if (int'(a) < L) cd[a] = d;
        if (int'(a) < 3) cs[a] = d;
    endtask

    task automatic pulse_sample(input logic signed [W-1:0] v);
        @(negedge sys_clk);
        sam_clk_en = 1'b1; x_in = v;
        model_push(longint'(v));
        @(negedge sys_clk);
        sam_clk_en = 1'b0;
    endtask

    // Watches both outputs for 21 cycles; latency counts cycles since the strobe.
    task automatic capture(input int start, output int ld, output int ls, output int nd,
                           output int ns, output logic signed [W-1:0] yd,
                           output logic signed [W-1:0] ys);
        ld = -1; ls = -1; nd = 0; ns = 0; yd = 'x; ys = 'x;
        for (int i = start; i <= start + 20; i++) begin
            @(negedge sys_clk);
            if (yv_d) begin nd++; if (ld < 0) begin ld = i; yd = y_d; end end
            if (yv_s) begin ns++; if (ls < 0) begin ls = i; ys = y_s; end end
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({y_d, yv_d, ov_d, cr_d} !== {18'sd0, 1'b0, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL reset_dir: got y=%0d v=%b ov=%b rdy=%b expected 0 0 0 1", y_d, yv_d, ov_d, cr_d);
        end
        checks++;
        if ({y_s, yv_s, ov_s, cr_s} !== {18'sd0, 1'b0, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL reset_sym: got y=%0d v=%b ov=%b rdy=%b expected 0 0 0 1", y_s, yv_s, ov_s, cr_s);
        end
    endtask

    task automatic test_impulse_direct();
        int ld, ls, nd, ns;
        logic signed [W-1:0] yd, ys;
        longint e;
        do_reset();
        for (int a = 0; a < L; a++) load_coef(AW'(a), 18'sd65536);
        for (int s = 0; s < 6; s++) begin
            pulse_sample((s == 0) ? 18'sd65536 : 18'sd0);
            capture(2, ld, ls, nd, ns, yd, ys);
            e = (s < 5) ? 32768 : 0;
            checks++;
            if (yd !== e) begin failures++; $display("FAIL imp_dir_y[%0d]: got %0d expected %0d", s, yd, e); end
            checks++;
            if (ld !== 7 || nd !== 1) begin failures++; $display("FAIL imp_dir_lat[%0d]: got lat=%0d pulses=%0d expected 7 1", s, ld, nd); end
            checks++;
            if (y_d !== yd) begin failures++; $display("FAIL imp_dir_hold[%0d]: got %0d expected %0d", s, y_d, yd); end
            e = exp_sym();
            checks++;
            if (ys !== e || ls !== 5 || ns !== 1) begin
                failures++;
                $display("FAIL imp_dir_symdut[%0d]: got y=%0d lat=%0d n=%0d expected %0d 5 1", s, ys, ls, ns, e);
            end
        end
    endtask

    task automatic test_impulse_sym();
        int ld, ls, nd, ns;
        logic signed [W-1:0] yd, ys;
        longint e;
        longint ref_y[6] = '{8192, 16384, 32768, 16384, 8192, 0};
        do_reset();
        load_coef(7'd0, 18'sd16384);
        load_coef(7'd1, 18'sd32768);
        load_coef(7'd2, 18'sd65536);
        for (int s = 0; s < 6; s++) begin
            pulse_sample((s == 0) ? 18'sd65536 : 18'sd0);
            capture(2, ld, ls, nd, ns, yd, ys);
            checks++;
            if (ys !== ref_y[s]) begin failures++; $display("FAIL imp_sym_y[%0d]: got %0d expected %0d", s, ys, ref_y[s]); end
            checks++;
            if (ls !== 5 || ns !== 1) begin failures++; $display("FAIL imp_sym_lat[%0d]: got lat=%0d pulses=%0d expected 5 1", s, ls, ns); end
            e = exp_dir();
            checks++;
            if (yd !== e || ld !== 7) begin failures++; $display("FAIL imp_sym_dirdut[%0d]: got y=%0d lat=%0d expected %0d 7", s, yd, ld, e); end
        end
    endtask

    task automatic test_saturation();
        int ld, ls, nd, ns;
        logic signed [W-1:0] yd, ys, v;
        longint ed, es;
        do_reset();
        for (int a = 0; a < L; a++) load_coef(AW'(a), 18'sd131071);
        for (int s = 0; s < 10; s++) begin
            v = (s < 5) ? 18'sd131071 : -18'sd131072;
            pulse_sample(v);
            capture(2, ld, ls, nd, ns, yd, ys);
            ed = exp_dir();
            es = exp_sym();
            checks++;
            if (yd !== ed || ys !== es) begin
                failures++;
                $display("FAIL sat_model[%0d]: got %0d/%0d expected %0d/%0d", s, yd, ys, ed, es);
            end
        end
        checks++;
        if (yd !== -18'sd131072 || ys !== -18'sd131072) begin
            failures++;
            $display("FAIL sat_neg: got %0d/%0d expected -131072", yd, ys);
        end
        for (int s = 0; s < 5; s++) begin
            pulse_sample(18'sd131071);
            capture(2, ld, ls, nd, ns, yd, ys);
        end
        checks++;
        if (yd !== 18'sd131071 || ys !== 18'sd131071) begin
            failures++;
            $display("FAIL sat_pos: got %0d/%0d expected 131071", yd, ys);
        end
    endtask

    task automatic test_random();
        int ld, ls, nd, ns;
        logic signed [W-1:0] yd, ys, d;
        longint ed, es;
        do_reset();
        for (int a = 0; a < 8; a++) begin
            d = W'($urandom);
            d = d >>> $urandom_range(0, 3);
            load_coef(AW'(a), d);
        end
        for (int s = 0; s < 14; s++) begin
            if (s == 7) load_coef(AW'($urandom_range(0, 6)), W'($urandom));
            pulse_sample(W'($urandom));
            capture(2, ld, ls, nd, ns, yd, ys);
            ed = exp_dir();
            es = exp_sym();
            checks++;
            if (yd !== ed) begin failures++; $display("FAIL rand_dir[%0d]: got %0d expected %0d", s, yd, ed); end
            checks++;
            if (ys !== es) begin failures++; $display("FAIL rand_sym[%0d]: got %0d expected %0d", s, ys, es); end
        end
    endtask

    task automatic test_back_to_back();
        longint qd[$], qs[$];
        longint e;
        int m = 8;
        do_reset();
        for (int a = 0; a < L; a++) load_coef(AW'(a), W'($urandom) >>> 1);
        for (int c = 0; c < 7*m + 12; c++) begin
            @(negedge sys_clk);
            if (yv_d) begin
                checks++;
                e = (qd.size() > 0) ? qd.pop_front() : 64'sd999999;
                if (y_d !== e) begin failures++; $display("FAIL b2b_dir@%0d: got %0d expected %0d", c, y_d, e); end
            end
            if (yv_s) begin
                checks++;
                e = (qs.size() > 0) ? qs.pop_front() : 64'sd999999;
                if (y_s !== e) begin failures++; $display("FAIL b2b_sym@%0d: got %0d expected %0d", c, y_s, e); end
            end
            if ((c % 7 == 0) && (c / 7 < m)) begin
                sam_clk_en = 1'b1;
                x_in = W'($urandom);
                model_push(longint'(x_in));
                qd.push_back(exp_dir());
                qs.push_back(exp_sym());
            end else begin
                sam_clk_en = 1'b0;
            end
        end
        checks++;
        if (qd.size() != 0 || qs.size() != 0) begin
            failures++;
            $display("FAIL b2b_missing: got %0d/%0d outstanding expected 0/0", qd.size(), qs.size());
        end
        checks++;
        if (ov_d !== 1'b0 || ov_s !== 1'b0) begin
            failures++;
            $display("FAIL b2b_overrun: got %b/%b expected 0/0", ov_d, ov_s);
        end
    endtask

    task automatic test_overrun();
        int ld, ls, nd, ns;
        logic signed [W-1:0] yd, ys;
        longint ed, es;
        do_reset();
        for (int a = 0; a < L; a++) load_coef(AW'(a), W'($urandom) >>> 1);
        pulse_sample(W'($urandom));
        ed = exp_dir();
        es = exp_sym();
        @(negedge sys_clk);
        @(negedge sys_clk);
        sam_clk_en = 1'b1;
        x_in = W'($urandom) | 18'sd1;
        @(negedge sys_clk);
        sam_clk_en = 1'b0;
        capture(5, ld, ls, nd, ns, yd, ys);
        checks++;
        if (yd !== ed || ld !== 7) begin failures++; $display("FAIL ovr_first_dir: got y=%0d lat=%0d expected %0d 7", yd, ld, ed); end
        checks++;
        if (ys !== es || ls !== 5) begin failures++; $display("FAIL ovr_first_sym: got y=%0d lat=%0d expected %0d 5", ys, ls, es); end
        checks++;
        if (ov_d !== 1'b1 || ov_s !== 1'b1) begin failures++; $display("FAIL ovr_flag: got %b/%b expected 1/1", ov_d, ov_s); end
        pulse_sample(W'($urandom));
        capture(2, ld, ls, nd, ns, yd, ys);
        ed = exp_dir();
        es = exp_sym();
        checks++;
        if (yd !== ed || ys !== es) begin
            failures++;
            $display("FAIL ovr_dropped: got %0d/%0d expected %0d/%0d", yd, ys, ed, es);
        end
        checks++;
        if (ov_d !== 1'b1 || ov_s !== 1'b1) begin failures++; $display("FAIL ovr_sticky: got %b/%b expected 1/1", ov_d, ov_s); end
        do_reset();
        checks++;
        if (ov_d !== 1'b0 || ov_s !== 1'b0) begin failures++; $display("FAIL ovr_clear: got %b/%b expected 0/0", ov_d, ov_s); end
    endtask

    task automatic test_coef_lock();
        int ld, ls, nd, ns;
        logic signed [W-1:0] yd, ys, d;
        longint ed, es;
        do_reset();
        for (int a = 0; a < L; a++) load_coef(AW'(a), W'($urandom) >>> 1);
        pulse_sample(W'($urandom));
        @(negedge sys_clk);
        checks++;
        if (cr_d !== 1'b0 || cr_s !== 1'b0) begin failures++; $display("FAIL lock_ready: got %b/%b expected 0/0", cr_d, cr_s); end
        d = W'($urandom);
        if (d == W'(cd[0])) d = d + 18'sd1;
        coef_wr = 1'b1; coef_addr = 7'd0; coef_data = d;
        @(negedge sys_clk);
        coef_wr = 1'b0;
        capture(4, ld, ls, nd, ns, yd, ys);
        ed = exp_dir();
        es = exp_sym();
        checks++;
        if (yd !== ed || ys !== es) begin
            failures++;
            $display("FAIL lock_ignored: got %0d/%0d expected %0d/%0d", yd, ys, ed, es);
        end
        @(negedge sys_clk);
        d = W'($urandom);
        sam_clk_en = 1'b1; x_in = W'($urandom);
        coef_wr = 1'b1; coef_addr = 7'd1; coef_data = d;
        cd[1] = d;
        cs[1] = d;
        model_push(longint'(x_in));
        @(negedge sys_clk);
        sam_clk_en = 1'b0; coef_wr = 1'b0;
        capture(2, ld, ls, nd, ns, yd, ys);
        ed = exp_dir();
        es = exp_sym();
        checks++;
        if (yd !== ed || ys !== es) begin
            failures++;
            $display("FAIL lock_same_cycle: got %0d/%0d expected %0d/%0d", yd, ys, ed, es);
        end
    endtask

    task automatic test_reset_mid_mac();
        int ld, ls, nd, ns;
        logic signed [W-1:0] yd, ys;
        longint e;
        do_reset();
        for (int a = 0; a < L; a++) load_coef(AW'(a), 18'sd65536);
        for (int s = 0; s < 3; s++) begin
            pulse_sample(W'($urandom));
            capture(2, ld, ls, nd, ns, yd, ys);
        end
        pulse_sample(W'($urandom));
        @(negedge sys_clk);
        reset = 1'b1;
        @(negedge sys_clk);
        reset = 1'b0;
        hist.delete();
        for (int j = 0; j < L; j++) cd[j] = 0;
        for (int j = 0; j < 3; j++) cs[j] = 0;
        capture(4, ld, ls, nd, ns, yd, ys);
        checks++;
        if (nd !== 0 || ns !== 0) begin failures++; $display("FAIL abort_valid: got %0d/%0d pulses expected 0/0", nd, ns); end
        checks++;
        if (y_d !== 18'sd0 || y_s !== 18'sd0 || cr_d !== 1'b1) begin
            failures++;
            $display("FAIL abort_state: got y=%0d/%0d rdy=%b expected 0/0 1", y_d, y_s, cr_d);
        end
        for (int a = 0; a < L; a++) load_coef(AW'(a), 18'sd65536);
        for (int s = 0; s < 6; s++) begin
            pulse_sample((s == 0) ? 18'sd65536 : 18'sd0);
            capture(2, ld, ls, nd, ns, yd, ys);
            e = (s < 5) ? 32768 : 0;
            checks++;
            if (yd !== e || ld !== 7) begin failures++; $display("FAIL abort_rerun[%0d]: got y=%0d lat=%0d expected %0d 7", s, yd, ld, e); end
            e = exp_sym();
            checks++;
            if (ys !== e) begin failures++; $display("FAIL abort_rerun_sym[%0d]: got %0d expected %0d", s, ys, e); end
        end
    endtask

    initial begin
        reset = 1'b1; sam_clk_en = 1'b0; x_in = '0;
        coef_wr = 1'b0; coef_addr = '0; coef_data = '0;
        test_reset();
        test_impulse_direct();
        test_impulse_sym();
        test_saturation();
        test_random();
        test_back_to_back();
        test_overrun();
        test_coef_lock();
        test_reset_mid_mac();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
